// File: rtl/late_sum_pkg.sv
// rtl/late_sum_pkg.sv - shared constants and state codes for the late-operand scheduler
// Contents: operand width W, response codes OUT_HI/OUT_LO, default threshold,
//           FSM state codes ST_IDLE/ST_WAIT_A/ST_CALC/ST_RESP.
package late_sum_pkg;

  localparam int W = 3;

  localparam logic [W-1:0] OUT_HI     = 3'b101;
  localparam logic [W-1:0] OUT_LO     = 3'b010;
  localparam logic [W-1:0] THRESH_DEF = 3'd4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT_A = 2'd1;
  localparam logic [1:0] ST_CALC   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/late_sum_sched_if.sv
// rtl/late_sum_sched_if.sv - requester/response bundle for late_sum_sched
// Signals: req, b_in, a_late, a_vld (requester side drives);
//          gnt, busy, rsp_vld, rsp_id, rsp_out, rsp_err (scheduler drives).
// Modports: master = requester side, slave = scheduler side.
// N_REQ and IDW must match the scheduler instance this bundle is bound to.
interface late_sum_sched_if
  import late_sum_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]   req;
  logic [W*N_REQ-1:0] b_in;
  logic [W*N_REQ-1:0] a_late;
  logic [N_REQ-1:0]   a_vld;
  logic [N_REQ-1:0]   gnt;
  logic               busy;
  logic               rsp_vld;
  logic [IDW-1:0]     rsp_id;
  logic [W-1:0]       rsp_out;
  logic               rsp_err;

  modport master (
    output req, b_in, a_late, a_vld,
    input  gnt, busy, rsp_vld, rsp_id, rsp_out, rsp_err
  );

  modport slave (
    input  req, b_in, a_late, a_vld,
    output gnt, busy, rsp_vld, rsp_id, rsp_out, rsp_err
  );
endinterface

// File: rtl/late_sum_sched_rr_arb.sv
// rtl/late_sum_sched_rr_arb.sv - combinational round-robin picker
// Ports: req  - request vector
//        ptr  - index to start searching from (wraps)
//        gnt  - one-hot winner, idx - encoded winner, any - some request is high
module rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   idx,
  output logic             any
);

  int             j;
  logic [IDW-1:0] jj;

  // Walk N_REQ positions starting at ptr; the first high request wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jj = IDW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        idx     = jj;
        gnt[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/late_sum_sched.sv
// rtl/late_sum_sched.sv - round-robin scheduler for a shared 3-bit add/compare with late operand
// Ports: clk, rst_n (async active-low), bus (late_sum_sched_if.slave).
// Optional macro LATE_TIMEOUT_EN: bounds the wait for a_late to TIMEOUT cycles and
// answers with OUT_LO and rsp_err=1 on expiry; without it rsp_err is tied low.
module late_sum_sched
  import late_sum_pkg::*;
#(
  parameter int         N_REQ   = 4,
  parameter logic [2:0] THRESH  = THRESH_DEF,
  parameter int         TIMEOUT = 8
) (
  input logic             clk,
  input logic             rst_n,
  late_sum_sched_if.slave bus
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]       state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     sum;
  logic [N_REQ-1:0] gnt_q;
  logic             vld_q;
  logic [IDW-1:0]   rid_q;
  logic [W-1:0]     rout_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDW-1:0]   arb_idx;
  logic             arb_any;

  // Per-lane operand views so lane selection is a plain array index.
  logic [W-1:0] b_arr [N_REQ];
  logic [W-1:0] a_arr [N_REQ];
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign b_arr[i] = bus.b_in[W*i +: W];
    assign a_arr[i] = bus.a_late[W*i +: W];
  end

  rr_arb #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req (bus.req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Carry out of the 3-bit add is intentionally dropped.
  assign sum = a_q + b_q;

`ifdef LATE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          err_q;
  assign bus.rsp_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign bus.rsp_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      id     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      gnt_q  <= '0;
      vld_q  <= 1'b0;
      rid_q  <= '0;
      rout_q <= '0;
`ifdef LATE_TIMEOUT_EN
      cnt    <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      vld_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            gnt_q <= arb_gnt;
            id    <= arb_idx;
            b_q   <= b_arr[arb_idx];
            state <= ST_WAIT_A;
`ifdef LATE_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        ST_WAIT_A: begin
          // A dropped request abandons the slot without advancing the pointer.
          if (!bus.req[id]) begin
            gnt_q <= '0;
            state <= ST_IDLE;
          end else if (bus.a_vld[id]) begin
            a_q   <= a_arr[id];
            state <= ST_CALC;
          end
`ifdef LATE_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            rout_q <= OUT_LO;
            err_q  <= 1'b1;
            rid_q  <= id;
            vld_q  <= 1'b1;
            state  <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ST_CALC: begin
          rout_q <= (sum >= THRESH) ? OUT_HI : OUT_LO;
          rid_q  <= id;
          vld_q  <= 1'b1;
          state  <= ST_RESP;
`ifdef LATE_TIMEOUT_EN
          err_q  <= 1'b0;
`endif
        end
        ST_RESP: begin
          ptr   <= (id == IDW'(N_REQ - 1)) ? '0 : id + 1'b1;
          gnt_q <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state != ST_IDLE);
  assign bus.rsp_vld = vld_q;
  assign bus.rsp_id  = rid_q;
  assign bus.rsp_out = rout_q;

endmodule
